// File: rtl/instr_fetch_reg.sv
// Fetch stage of the multicycle CPU.
// Holds the program counter, fetches one instruction word per Fetch command
// over a req/ack memory handshake, latches it into IR and advances PC by 4.
// A misaligned PC write or a memory that never acknowledges sets a sticky Fault.
//
// Memory handshake: ImemReq is high for every cycle the FSM sits in FETCH and
// ImemAddr always equals PC. The word is taken in the first cycle that
// ImemAck is sampled high while ImemReq is high (ImemData is valid in that
// same cycle). If TIMEOUT request cycles pass without an ack, the request is
// abandoned and ImemReq drops in the following cycle. An ack that arrives
// while ImemReq is low is ignored.
module instr_fetch_reg #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned TIMEOUT  = 15
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        Fetch,
   input  logic        PCWrite,
   input  logic [31:0] PCNext,
   output logic        ImemReq,
   output logic [31:0] ImemAddr,
   input  logic        ImemAck,
   input  logic [31:0] ImemData,
   output logic [31:0] IR,
   output logic [5:0]  Op,
   output logic [4:0]  Rs,
   output logic [4:0]  Rt,
   output logic [4:0]  Rd,
   output logic [4:0]  Sa,
   output logic [15:0] Imm16,
   output logic [31:0] PC,
   output logic [31:0] PC4,
   output logic        IRValid,
   output logic        Done,
   output logic        Busy,
   output logic        Fault,
   output logic [1:0]  DbgState
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   // Last request-cycle index before the fetch is abandoned.
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_ir;
   logic        r_irvalid;
   logic        r_fault;
   logic [7:0]  r_cnt;

   logic        w_pcw_bad;
   logic        w_pcw_good;
   logic [31:0] w_pc_plus4;

   // PC writes are only accepted while the fetch path does not own PC.
   always_comb begin
      w_pcw_bad  = 1'b0;
      w_pcw_good = 1'b0;
      if (!r_fault && PCWrite && (r_state != S_FETCH)) begin
         w_pcw_bad  = (PCNext[1:0] != 2'b00);
         w_pcw_good = (PCNext[1:0] == 2'b00);
      end
   end

   assign w_pc_plus4 = r_pc + 32'd4;

   // Fetch FSM: PC, IR, timeout counter and sticky fault in one register block.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state   <= S_IDLE;
         r_pc      <= RESET_PC;
         r_ir      <= 32'd0;
         r_irvalid <= 1'b0;
         r_fault   <= 1'b0;
         r_cnt     <= 8'd0;
      end else begin
         if (w_pcw_bad) begin
            r_fault <= 1'b1;
         end
         case (r_state)
            S_IDLE: begin
               if (w_pcw_good) begin
                  r_pc <= PCNext;
               end
               // A misaligned write in the same cycle also cancels the fetch.
               if (Fetch && !r_fault && !w_pcw_bad) begin
                  r_state <= S_FETCH;
                  r_cnt   <= 8'd0;
               end
            end
            S_FETCH: begin
               if (ImemAck) begin
                  r_ir      <= ImemData;
                  r_pc      <= w_pc_plus4;
                  r_irvalid <= 1'b1;
                  r_state   <= S_DONE;
               end else if (r_cnt == TO_LAST) begin
                  r_fault <= 1'b1;
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            S_DONE: begin
               // A branch target written here replaces the +4 just applied.
               if (w_pcw_good) begin
                  r_pc <= PCNext;
               end
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign ImemReq  = (r_state == S_FETCH);
   assign Busy     = (r_state == S_FETCH);
   assign Done     = (r_state == S_DONE);
   assign DbgState = r_state;
   assign ImemAddr = r_pc;
   assign PC       = r_pc;
   assign PC4      = w_pc_plus4;
   assign IR       = r_ir;
   assign IRValid  = r_irvalid;
   assign Fault    = r_fault;
   assign Op       = r_ir[31:26];
   assign Rs       = r_ir[25:21];
   assign Rt       = r_ir[20:16];
   assign Rd       = r_ir[15:11];
   assign Sa       = r_ir[10:6];
   assign Imm16    = r_ir[15:0];

endmodule

// File: tb/tb_instr_fetch_reg.sv
// Bench for instr_fetch_reg: random fetches with a responding memory model,
// a scoreboard of expected completions/faults, and directed corner cases.
module tb_instr_fetch_reg;

   localparam int          TIMEOUT  = 15;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        CLK;
   logic        RST;
   logic        Fetch;
   logic        PCWrite;
   logic [31:0] PCNext;
   logic        ImemReq;
   logic [31:0] ImemAddr;
   logic        ImemAck;
   logic [31:0] ImemData;
   logic [31:0] IR;
   logic [5:0]  Op;
   logic [4:0]  Rs;
   logic [4:0]  Rt;
   logic [4:0]  Rd;
   logic [4:0]  Sa;
   logic [15:0] Imm16;
   logic [31:0] PC;
   logic [31:0] PC4;
   logic        IRValid;
   logic        Done;
   logic        Busy;
   logic        Fault;
   logic [1:0]  DbgState;

   instr_fetch_reg #(
      .RESET_PC (RESET_PC),
      .TIMEOUT  (TIMEOUT)
   ) dut (
      .CLK      (CLK),
      .RST      (RST),
      .Fetch    (Fetch),
      .PCWrite  (PCWrite),
      .PCNext   (PCNext),
      .ImemReq  (ImemReq),
      .ImemAddr (ImemAddr),
      .ImemAck  (ImemAck),
      .ImemData (ImemData),
      .IR       (IR),
      .Op       (Op),
      .Rs       (Rs),
      .Rt       (Rt),
      .Rd       (Rd),
      .Sa       (Sa),
      .Imm16    (Imm16),
      .PC       (PC),
      .PC4      (PC4),
      .IRValid  (IRValid),
      .Done     (Done),
      .Busy     (Busy),
      .Fault    (Fault),
      .DbgState (DbgState)
   );

   // ---------------- clock ----------------
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // ---------------- scoreboard state ----------------
   int checks = 0;
   int errors = 0;
   // Entry: {is_fault_event, expected IR, expected PC}
   logic [64:0] exp_q[$];

   // Reference model state
   logic [31:0] m_pc;
   logic [31:0] m_ir;
   logic        m_fault;
   logic        m_irvalid;

   // Memory responder control
   int resp_delay = 0;
   bit resp_en    = 1'b1;

   // Instruction memory contents as a function of address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'd0) return 32'h2010_0005;
      return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1 ^ (a << 3);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- memory responder ----------------
   initial begin
      int req_cycles;
      req_cycles = 0;
      forever begin
         @(negedge CLK);
         if (resp_en) begin
            if (ImemReq) begin
               if (req_cycles == resp_delay) begin
                  ImemAck  = 1'b1;
                  ImemData = mem_word(ImemAddr);
               end else begin
                  ImemAck  = 1'b0;
                  ImemData = $urandom;
               end
               req_cycles++;
            end else begin
               ImemAck    = 1'b0;
               req_cycles = 0;
            end
         end else begin
            req_cycles = 0;
         end
      end
   end

   // ---------------- monitor ----------------
   initial begin
      logic        prev_fault;
      logic [64:0] e;
      prev_fault = 1'b0;
      forever begin
         @(negedge CLK);
         if (RST) begin
            prev_fault = 1'b0;
         end else begin
            if (Done) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_done actual=1 required=0 (t=%0t)", $time);
               end else begin
                  e = exp_q.pop_front();
                  chk("sb_done_kind", 32'(e[64]), 32'd0);
                  chk("sb_done_ir", IR, e[63:32]);
                  chk("sb_done_pc", PC, e[31:0]);
               end
            end
            if (Fault && !prev_fault) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_fault actual=1 required=0 (t=%0t)", $time);
               end else begin
                  e = exp_q.pop_front();
                  chk("sb_fault_kind", 32'(e[64]), 32'd1);
                  chk("sb_fault_ir", IR, e[63:32]);
                  chk("sb_fault_pc", PC, e[31:0]);
               end
            end
            prev_fault = Fault;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      @(negedge CLK);
      RST     = 1'b1;
      Fetch   = 1'b0;
      PCWrite = 1'b0;
      PCNext  = 32'd0;
      exp_q.delete();
      m_pc      = RESET_PC;
      m_ir      = 32'd0;
      m_fault   = 1'b0;
      m_irvalid = 1'b0;
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
      chk("rst_pc", PC, RESET_PC);
      chk("rst_ir", IR, 32'd0);
      chk("rst_irvalid", IRValid, 32'd0);
      chk("rst_fault", Fault, 32'd0);
      chk("rst_req", ImemReq, 32'd0);
      chk("rst_done", Done, 32'd0);
   endtask

   // One command: optional PC write plus Fetch in the same cycle. delay is the
   // number of request cycles the memory waits before acking (>= TIMEOUT: never).
   task automatic fetch_txn(input bit pcw, input logic [31:0] pcn, input int delay);
      bit go;
      bit finished;
      @(negedge CLK);
      resp_delay = delay;
      PCWrite    = pcw;
      PCNext     = pcn;
      Fetch      = 1'b1;
      go = !m_fault;
      if (!m_fault && pcw) begin
         if (pcn[1:0] != 2'b00) begin
            m_fault = 1'b1;
            go      = 1'b0;
            exp_q.push_back({1'b1, m_ir, m_pc});
         end else begin
            m_pc = pcn;
         end
      end
      if (go) begin
         if (delay < TIMEOUT) begin
            m_ir      = mem_word(m_pc);
            m_pc      = m_pc + 32'd4;
            m_irvalid = 1'b1;
            exp_q.push_back({1'b0, m_ir, m_pc});
         end else begin
            m_fault = 1'b1;
            exp_q.push_back({1'b1, m_ir, m_pc});
         end
      end
      @(negedge CLK);
      Fetch   = 1'b0;
      PCWrite = 1'b0;
      finished = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (!Busy && !Done) begin
            finished = 1'b1;
            break;
         end
         @(negedge CLK);
      end
      if (!finished) begin
         checks++;
         errors++;
         $display("FAIL wait_idle actual=busy required=idle (t=%0t)", $time);
      end
      chk("pc", PC, m_pc);
      chk("pc4", PC4, m_pc + 32'd4);
      chk("ir", IR, m_ir);
      chk("fault", Fault, m_fault);
      chk("irvalid", IRValid, m_irvalid);
      chk("req_idle", ImemReq, 32'd0);
      chk("op", Op, m_ir >> 26);
      chk("rs", Rs, (m_ir >> 21) & 32'h1F);
      chk("rt", Rt, (m_ir >> 16) & 32'h1F);
      chk("rd", Rd, (m_ir >> 11) & 32'h1F);
      chk("sa", Sa, (m_ir >> 6) & 32'h1F);
      chk("imm16", Imm16, m_ir & 32'hFFFF);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      RST      = 1'b1;
      Fetch    = 1'b0;
      PCWrite  = 1'b0;
      PCNext   = 32'd0;
      ImemAck  = 1'b0;
      ImemData = 32'd0;

      // Reset then first fetch from address 0, ack after 2 wait cycles.
      do_reset();
      fetch_txn(1'b0, 32'd0, 2);
      chk("t1_ir", IR, 32'h2010_0005);
      chk("t1_imm16", Imm16, 32'h0005);
      chk("t1_rt", Rt, 32'd16);
      chk("t1_pc", PC, 32'd4);

      // Branch target loaded together with Fetch.
      fetch_txn(1'b1, 32'h0000_0040, int'($urandom_range(0, 4)));
      chk("t2_pc", PC, 32'h0000_0044);
      chk("t2_ir", IR, mem_word(32'h0000_0040));

      // Random fetches, some with PC writes, ack latency across the full window.
      for (int n = 0; n < 25; n++) begin
         bit          pcw;
         logic [31:0] pcn;
         pcw = ($urandom_range(0, 2) == 0);
         pcn = $urandom & 32'hFFFF_FFFC;
         fetch_txn(pcw, pcn, int'($urandom_range(0, TIMEOUT - 1)));
      end
      // Ack on the last permitted request cycle still succeeds.
      fetch_txn(1'b0, 32'd0, TIMEOUT - 1);

      // PC write during DONE overrides the increment; Fetch in DONE is dropped.
      @(negedge CLK);
      resp_delay = 0;
      Fetch      = 1'b1;
      m_ir       = mem_word(m_pc);
      m_pc       = m_pc + 32'd4;
      exp_q.push_back({1'b0, m_ir, m_pc});
      @(negedge CLK);
      Fetch = 1'b0;
      @(negedge CLK);
      chk("dn_done", Done, 32'd1);
      PCWrite = 1'b1;
      PCNext  = 32'h0000_0100;
      Fetch   = 1'b1;
      m_pc    = 32'h0000_0100;
      @(negedge CLK);
      PCWrite = 1'b0;
      Fetch   = 1'b0;
      chk("dn_busy", Busy, 32'd0);
      chk("dn_pc", PC, 32'h0000_0100);
      @(negedge CLK);

      // Memory never acks: fault, then further Fetch and PCWrite ignored.
      fetch_txn(1'b0, 32'd0, TIMEOUT);
      fetch_txn(1'b0, 32'd0, 0);
      fetch_txn(1'b1, 32'h0000_0200, 0);

      // Misaligned PC write.
      do_reset();
      fetch_txn(1'b1, 32'h0000_0042, 0);

      // PC wrap at the top of the address space.
      do_reset();
      fetch_txn(1'b1, 32'hFFFF_FFFC, 3);
      chk("wrap_pc", PC, 32'h0000_0000);
      chk("wrap_pc4", PC4, 32'h0000_0004);
      chk("wrap_fault", Fault, 32'd0);

      // Reset during FETCH, then a late ack.
      do_reset();
      fetch_txn(1'b1, 32'h0000_0080, 1);
      resp_en = 1'b0;
      ImemAck = 1'b0;
      @(negedge CLK);
      Fetch = 1'b1;
      @(negedge CLK);
      Fetch = 1'b0;
      chk("mid_busy", Busy, 32'd1);
      @(negedge CLK);
      RST = 1'b1;
      exp_q.delete();
      #1;
      chk("mid_req", ImemReq, 32'd0);
      ImemAck  = 1'b1;
      ImemData = 32'hDEAD_BEEF;
      @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
      ImemAck = 1'b0;
      chk("mid_done", Done, 32'd0);
      @(negedge CLK);
      chk("mid_pc", PC, RESET_PC);
      chk("mid_ir", IR, 32'd0);
      chk("mid_irvalid", IRValid, 32'd0);
      chk("mid_fault", Fault, 32'd0);
      resp_en = 1'b1;

      repeat (3) @(negedge CLK);
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL sb_leftover actual=%0d required=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Absolute time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1);
   end

endmodule
